// File: rtl/uart_buffered_core.sv
// Buffered full-duplex UART: TX/RX FIFOs around serial engines with runtime divisor,
// parity and stop-bit selection, plus internal loopback of the TX line into the receiver.

module uart_buffered_core_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module uart_buffered_core #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [15:0]                     Divisor,
    input  logic [1:0]                      ParityMode,
    input  logic                            StopBits,
    input  logic                            Loopback,
    input  logic [DATA_BITS-1:0]            TxData,
    input  logic                            TxValid,
    output logic                            TxReady,
    output logic [DATA_BITS-1:0]            RxData,
    output logic                            RxValid,
    input  logic                            RxReady,
    output logic [$clog2(TX_DEPTH+1)-1:0]   TxCount,
    output logic [$clog2(RX_DEPTH+1)-1:0]   RxCount,
    output logic                            Tx,
    input  logic                            Rx,
    output logic                            ParityError,
    output logic                            FrameError,
    output logic                            RxOverrun
);
    localparam int unsigned BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    logic [15:0] div_eff;
    assign div_eff = (Divisor < 16'd4) ? 16'd4 : Divisor;

    // ---------------- TX path ----------------
    state_e                tx_state_q, tx_state_d;
    logic [15:0]           tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [1:0]            tx_pmode_q, tx_pmode_d;
    logic                  tx_stop2_q, tx_stop2_d, tx_par_q, tx_par_d, tx_q, tx_d;
    logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d, tx_head;
    logic [BW-1:0]         tx_bit_q, tx_bit_d;
    logic                  tx_pop, tx_empty, tx_full, tx_bit_end, tx_last_stop;

    uart_buffered_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(CLK), .rst_ni(RST), .push_i(TxValid), .wdata_i(TxData), .pop_i(tx_pop),
        .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(TxCount)
    );

    assign TxReady      = !tx_full;
    assign tx_bit_end   = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_last_stop = (tx_state_q == ST_STOP) && tx_bit_end && (!tx_stop2_q || tx_bit_q == BW'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'd4;
            tx_pmode_q <= '0;
            tx_stop2_q <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_pmode_q <= tx_pmode_d;
            tx_stop2_q <= tx_stop2_d;
            tx_par_q   <= tx_par_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_pmode_d = tx_pmode_q;
        tx_stop2_d = tx_stop2_q;
        tx_par_d   = tx_par_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        if (tx_state_q != ST_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 16'd1;
        case (tx_state_q)
            ST_IDLE: ;
            ST_START: if (tx_bit_end) begin
                tx_state_d = ST_DATA;
                tx_bit_d   = '0;
            end
            ST_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == BW'(DATA_BITS-1)) begin
                    tx_state_d = (^tx_pmode_q) ? ST_PARITY : ST_STOP;
                    tx_bit_d   = '0;
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            ST_PARITY: if (tx_bit_end) begin
                tx_state_d = ST_STOP;
                tx_bit_d   = '0;
            end
            ST_STOP: if (tx_bit_end) begin
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_last_stop) tx_state_d = ST_IDLE;
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // Loading overrides the end of STOP so the next START follows with no idle gap
        if (tx_pop) begin
            tx_state_d = ST_START;
            tx_cnt_d   = '0;
            tx_div_d   = div_eff;
            tx_pmode_d = ParityMode;
            tx_stop2_d = StopBits;
            tx_shift_d = tx_head;
            tx_par_d   = (^tx_head) ^ ParityMode[0];
        end
    end

    always_comb begin
        tx_pop = !tx_empty && ((tx_state_q == ST_IDLE) || tx_last_stop);
        case (tx_state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_shift_q[0];
            ST_PARITY: tx_d = tx_par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    assign Tx = Loopback ? 1'b1 : tx_q;

    // ---------------- RX path ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_in, rx_s, rx_prev_q;
    state_e                 rx_state_q, rx_state_d;
    logic [15:0]            rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [1:0]             rx_pmode_q, rx_pmode_d;
    logic                   rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [BW-1:0]          rx_bit_q, rx_bit_d;
    logic                   rx_half_end, rx_bit_end, rx_stop_sample, rx_par_bad;
    logic                   rx_push, rx_full, rx_empty;
    logic                   perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

    assign rx_in = Loopback ? tx_q : Rx;
    assign rx_s  = sync_q[SYNC_STAGES-1];

    uart_buffered_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(CLK), .rst_ni(RST), .push_i(rx_push), .wdata_i(rx_shift_q), .pop_i(RxReady),
        .rdata_o(RxData), .full_o(rx_full), .empty_o(rx_empty), .count_o(RxCount)
    );

    assign RxValid        = !rx_empty;
    assign rx_half_end    = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
    assign rx_bit_end     = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_stop_sample = (rx_state_q == ST_STOP) && rx_bit_end;
    assign rx_par_bad     = (^rx_pmode_q) && (((^rx_shift_q) ^ rx_par_q) != rx_pmode_q[0]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'd4;
            rx_pmode_q <= '0;
            rx_par_q   <= 1'b0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_pmode_q <= rx_pmode_d;
            rx_par_q   <= rx_par_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_pmode_d = rx_pmode_q;
        rx_par_d   = rx_par_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        if (rx_state_q != ST_IDLE) rx_cnt_d = rx_cnt_q + 16'd1;
        case (rx_state_q)
            ST_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = ST_START;
                rx_cnt_d   = '0;
                rx_div_d   = div_eff;
                rx_pmode_d = ParityMode;
            end
            ST_START: if (rx_half_end) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == BW'(DATA_BITS-1)) rx_state_d = (^rx_pmode_q) ? ST_PARITY : ST_STOP;
                else                              rx_bit_d   = rx_bit_q + 1'b1;
            end
            ST_PARITY: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_par_d   = rx_s;
                rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_state_d = ST_IDLE;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_push = rx_stop_sample && rx_s && !rx_par_bad;
        ferr_d  = rx_stop_sample && !rx_s;
        perr_d  = rx_stop_sample && rx_s && rx_par_bad;
        ovr_d   = rx_push && rx_full;
    end

    assign ParityError = perr_q;
    assign FrameError  = ferr_q;
    assign RxOverrun   = ovr_q;
endmodule

// File: tb/tb_uart_buffered_core.sv
// Scoreboard bench for uart_buffered_core: received words are checked against a queue
// of expected words filled when the corresponding frames are launched.

module tb_uart_buffered_core;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [15:0] Divisor = 16'd16;
    logic [1:0] ParityMode = 2'b00;
    logic       StopBits = 1'b0;
    logic       Loopback = 1'b0;
    logic [7:0] TxData = 8'hFF;
    logic       TxValid = 1'b1;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady = 1'b1;
    logic [4:0] TxCount;
    logic [2:0] RxCount;
    logic       Tx;
    logic       Rx = 1'b0;
    logic       ParityError, FrameError, RxOverrun;

    uart_buffered_core #(.DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .Divisor(Divisor), .ParityMode(ParityMode), .StopBits(StopBits),
        .Loopback(Loopback), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady), .TxCount(TxCount),
        .RxCount(RxCount), .Tx(Tx), .Rx(Rx), .ParityError(ParityError),
        .FrameError(FrameError), .RxOverrun(RxOverrun)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int perr_n = 0, ferr_n = 0, ovr_n = 0, lb_low_n = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (ParityError) perr_n++;
            if (FrameError)  ferr_n++;
            if (RxOverrun)   ovr_n++;
            if (Loopback && Tx !== 1'b1) lb_low_n++;
            if (RxValid && RxReady) begin
                if (exp_q.size() == 0) check_eq("rx_unexpected", 32'(RxValid), 32'd0);
                else                   check_eq("rx_data", 32'(RxData), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following the push.
    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        TxData  = d;
        TxValid = 1'b1;
        while (!TxReady && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 5000) check_eq("tx_ready_timeout", 32'(TxReady), 32'd1);
        @(negedge CLK);
        TxValid = 1'b0;
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input bit par_en, input logic par, input logic stop);
        Rx = 1'b0;
        repeat (16) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            repeat (16) @(negedge CLK);
        end
        if (par_en) begin
            Rx = par;
            repeat (16) @(negedge CLK);
        end
        Rx = stop;
        repeat (16) @(negedge CLK);
        Rx = 1'b1;
        repeat (16) @(negedge CLK);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge CLK);
            t++;
        end
        check_eq("rx_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a5;
        logic       frame [10];
        int b_perr, b_ferr, b_ovr, b_lb, t;

        // Reset held with active inputs
        repeat (3) @(negedge CLK);
        check_eq("rst_tx", 32'(Tx), 32'd1);
        check_eq("rst_txready", 32'(TxReady), 32'd1);
        check_eq("rst_rxvalid", 32'(RxValid), 32'd0);
        check_eq("rst_txcount", 32'(TxCount), 32'd0);
        check_eq("rst_rxcount", 32'(RxCount), 32'd0);
        check_eq("rst_errs", 32'({ParityError, FrameError, RxOverrun}), 32'd0);
        TxValid = 1'b0;
        Rx      = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // 8N1 waveform of 0xA5
        a5 = 8'hA5;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[i+1] = a5[i];
        frame[9] = 1'b1;
        push_tx(a5);
        check_eq("tx_count_after_push", 32'(TxCount), 32'd1);
        @(negedge CLK);
        check_eq("tx_count_after_pop", 32'(TxCount), 32'd0);
        check_eq("tx_idle_before_start", 32'(Tx), 32'd1);
        for (int i = 0; i < 160; i++) begin
            @(negedge CLK);
            check_eq("tx_bit", 32'(Tx), 32'(frame[i/16]));
        end
        @(negedge CLK);
        check_eq("tx_idle_after", 32'(Tx), 32'd1);
        repeat (10) @(negedge CLK);

        // Loopback 8E2, three words
        Loopback = 1'b1; ParityMode = 2'b10; StopBits = 1'b1;
        b_perr = perr_n; b_ferr = ferr_n; b_ovr = ovr_n; b_lb = lb_low_n;
        @(negedge CLK);
        exp_q.push_back(8'h3C); push_tx(8'h3C);
        exp_q.push_back(8'hFF); push_tx(8'hFF);
        exp_q.push_back(8'h00); push_tx(8'h00);
        wait_drain(3000);
        repeat (100) @(negedge CLK);
        check_eq("lb_errors", 32'((perr_n - b_perr) + (ferr_n - b_ferr) + (ovr_n - b_ovr)), 32'd0);
        check_eq("lb_tx_pin_high", 32'(lb_low_n - b_lb), 32'd0);
        Loopback = 1'b0;
        repeat (5) @(negedge CLK);

        // Odd parity: bad parity, good parity, then a framing error
        ParityMode = 2'b01; StopBits = 1'b0;
        b_perr = perr_n; b_ferr = ferr_n;
        drive_rx_frame(8'h55, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        check_eq("perr_pulse", 32'(perr_n - b_perr), 32'd1);
        check_eq("perr_rxvalid", 32'(RxValid), 32'd0);
        check_eq("perr_rxcount", 32'(RxCount), 32'd0);
        exp_q.push_back(8'h55);
        drive_rx_frame(8'h55, 1'b1, 1'b1, 1'b1);
        wait_drain(200);
        check_eq("perr_after_good", 32'(perr_n - b_perr), 32'd1);
        ParityMode = 2'b00;
        drive_rx_frame(8'h0F, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        check_eq("ferr_pulse", 32'(ferr_n - b_ferr), 32'd1);
        check_eq("ferr_rxcount", 32'(RxCount), 32'd0);

        // Overrun with RX_DEPTH=4
        RxReady = 1'b0; Loopback = 1'b1;
        b_perr = perr_n; b_ferr = ferr_n; b_ovr = ovr_n;
        @(negedge CLK);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i * 8'h11));
            push_tx(8'(i * 8'h11));
        end
        t = 0;
        while ((ovr_n - b_ovr) < 1 && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        repeat (50) @(negedge CLK);
        check_eq("ovr_pulse", 32'(ovr_n - b_ovr), 32'd1);
        check_eq("ovr_rxcount", 32'(RxCount), 32'd4);
        check_eq("ovr_head", 32'(RxData), 32'h11);
        check_eq("ovr_other_errs", 32'((perr_n - b_perr) + (ferr_n - b_ferr)), 32'd0);
        @(posedge CLK);
        #1 RxReady = 1'b1;
        wait_drain(100);
        @(negedge CLK);
        check_eq("ovr_rxcount_drained", 32'(RxCount), 32'd0);
        Loopback = 1'b0;
        repeat (5) @(negedge CLK);

        // False start, then a normal frame still received
        b_perr = perr_n; b_ferr = ferr_n; b_ovr = ovr_n;
        Rx = 1'b0;
        repeat (4) @(negedge CLK);
        Rx = 1'b1;
        repeat (400) @(negedge CLK);
        check_eq("fstart_rxcount", 32'(RxCount), 32'd0);
        check_eq("fstart_errs", 32'((perr_n - b_perr) + (ferr_n - b_ferr) + (ovr_n - b_ovr)), 32'd0);
        exp_q.push_back(8'hC3);
        drive_rx_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        wait_drain(200);

        // Reset in the middle of a TX frame
        push_tx(8'h5A);
        push_tx(8'h96);
        repeat (40) @(negedge CLK);
        check_eq("mid_txcount", 32'(TxCount), 32'd1);
        check_eq("mid_tx_busy", 32'(Tx), 32'(8'h5A >> 1 & 1) ^ 32'd0);
        #2 RST = 1'b0;
        #1;
        check_eq("abort_tx", 32'(Tx), 32'd1);
        check_eq("abort_txcount", 32'(TxCount), 32'd0);
        check_eq("abort_txready", 32'(TxReady), 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (300) @(negedge CLK);
        check_eq("post_abort_idle", 32'(Tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
